// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter_if : processor fetch/load-store ports + memory port  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic              IGnt;
  logic              IValid;
  logic [DATA_W-1:0] IData;

  logic              DReadEn;
  logic              DWriteEn;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWData;
  logic              DGnt;
  logic              DValid;
  logic [DATA_W-1:0] DRData;

  logic              Stall;

  logic [ADDR_W-1:0] MemAddr;
  logic              MemRead;
  logic              MemWrite;
  logic [DATA_W-1:0] MemWData;
  logic [DATA_W-1:0] MemRData;

  // Arbiter side
  modport slave (
    input  IReq, IAddr, DReadEn, DWriteEn, DAddr, DWData, MemRData,
    output IGnt, IValid, IData, DGnt, DValid, DRData, Stall,
           MemAddr, MemRead, MemWrite, MemWData
  );

  // Processor + memory side
  modport master (
    output IReq, IAddr, DReadEn, DWriteEn, DAddr, DWData, MemRData,
    input  IGnt, IValid, IData, DGnt, DValid, DRData, Stall,
           MemAddr, MemRead, MemWrite, MemWData
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter : shares one single-ported memory between fetch and  |
// | load/store, data priority with a fetch starvation limit.              |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic         Clock,
  input  wire logic         nReset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    RSP_NONE  = 2'd0,
    RSP_INSTR = 2'd1,
    RSP_DATA  = 2'd2
  } rsp_owner_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  rsp_owner_t        rsp_owner;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] idata_hold;
  logic [DATA_W-1:0] drdata_hold;

  logic              d_req;
  logic              fetch_prio;
  logic              fetch_gnt;
  logic              data_gnt;
  logic              store_gnt;
  logic              ivalid;
  logic              dvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;

  always_comb begin
    d_req      = bus.DReadEn | bus.DWriteEn;
    fetch_prio = bus.IReq & (starve_cnt == STARVE_MAX);
    data_gnt   = d_req & ~fetch_prio;
    fetch_gnt  = bus.IReq & ~data_gnt;
    store_gnt  = data_gnt & bus.DWriteEn;
  end

  // A combined read+write request is treated as a plain store.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (fetch_gnt) begin
      mem_addr = bus.IAddr;
      mem_read = 1'b1;
    end else if (store_gnt) begin
      mem_addr  = bus.DAddr;
      mem_wdata = bus.DWData;
      mem_write = 1'b1;
    end else if (data_gnt) begin
      mem_addr = bus.DAddr;
      mem_read = 1'b1;
    end
  end

  assign ivalid = (rsp_owner == RSP_INSTR);
  assign dvalid = (rsp_owner == RSP_DATA);

  assign bus.IGnt     = fetch_gnt;
  assign bus.DGnt     = data_gnt;
  assign bus.Stall    = (bus.IReq & ~fetch_gnt) | (d_req & ~data_gnt);
  assign bus.MemAddr  = mem_addr;
  assign bus.MemRead  = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.MemWData = mem_wdata;
  assign bus.IValid   = ivalid;
  assign bus.DValid   = dvalid;
  assign bus.IData    = ivalid ? bus.MemRData : idata_hold;
  assign bus.DRData   = dvalid ? bus.MemRData : drdata_hold;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rsp_owner   <= RSP_NONE;
      starve_cnt  <= 4'd0;
      idata_hold  <= '0;
      drdata_hold <= '0;
    end else begin
      if (fetch_gnt) begin
        rsp_owner <= RSP_INSTR;
      end else if (data_gnt && !bus.DWriteEn) begin
        rsp_owner <= RSP_DATA;
      end else begin
        rsp_owner <= RSP_NONE;
      end

      if (bus.IReq && !fetch_gnt) begin
        if (starve_cnt != STARVE_MAX) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= 4'd0;
      end

      if (ivalid) begin
        idata_hold <= bus.MemRData;
      end
      if (dvalid) begin
        drdata_hold <= bus.MemRData;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_port_arbiter : directed bench with response scoreboard         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;
  logic Clock;
  logic nReset;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (bus)
  );

  logic [31:0] mem [0:65535];
  logic [31:0] iq[$];
  logic [31:0] dq[$];
  int          n_pass;
  int          n_checks;
  logic        exp_d;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial bus.MemRData = 32'h0;
  always @(posedge Clock) begin
    if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemWData;
    if (bus.MemRead)  bus.MemRData <= mem[bus.MemAddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  task automatic checkb(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    bus.IReq     = 1'b0;
    bus.IAddr    = 16'h0;
    bus.DReadEn  = 1'b0;
    bus.DWriteEn = 1'b0;
    bus.DAddr    = 16'h0;
    bus.DWData   = 32'h0;
  endtask

  // Scoreboard: every response must match the oldest expected word of its port.
  always @(negedge Clock) begin
    if (nReset) begin
      checkb("valid_exclusive", bus.IValid & bus.DValid, 1'b0);
      if (bus.IValid) begin
        if (iq.size() == 0) checkb("ivalid_unexpected", bus.IValid, 1'b0);
        else check("sb_idata", bus.IData, iq.pop_front());
      end
      if (bus.DValid) begin
        if (dq.size() == 0) checkb("dvalid_unexpected", bus.DValid, 1'b0);
        else check("sb_drdata", bus.DRData, dq.pop_front());
      end
    end
  end

  initial begin
    n_pass   = 0;
    n_checks = 0;
    nReset   = 1'b0;
    idle();
    mem[16'h0000] = 32'hA0A00000;
    mem[16'h0004] = 32'h3C011234;
    mem[16'h0010] = 32'h00000000;
    mem[16'h0020] = 32'hD0D02020;
    mem[16'h0030] = 32'h00000000;

    repeat (2) @(posedge Clock);
    #3;
    checkb("rst_ivalid", bus.IValid, 1'b0);
    checkb("rst_dvalid", bus.DValid, 1'b0);
    check("rst_idata", bus.IData, 32'h0);
    check("rst_drdata", bus.DRData, 32'h0);
    checkb("rst_stall", bus.Stall, 1'b0);
    checkb("rst_memread", bus.MemRead, 1'b0);
    check("rst_memaddr", 32'(bus.MemAddr), 32'h0);
    tick();
    nReset = 1'b1;

    // Single fetch
    tick();
    bus.IReq = 1'b1; bus.IAddr = 16'h0004; #3;
    checkb("s1_ignt", bus.IGnt, 1'b1);
    checkb("s1_dgnt", bus.DGnt, 1'b0);
    checkb("s1_stall", bus.Stall, 1'b0);
    checkb("s1_memread", bus.MemRead, 1'b1);
    check("s1_memaddr", 32'(bus.MemAddr), 32'h4);
    iq.push_back(32'h3C011234);
    tick(); idle(); #3;
    checkb("s1_ivalid", bus.IValid, 1'b1);
    check("s1_idata", bus.IData, 32'h3C011234);
    tick(); #3;
    checkb("s1_ivalid_low", bus.IValid, 1'b0);
    check("s1_idata_hold", bus.IData, 32'h3C011234);

    // Contention: data wins four times, then fetch is forced through
    tick();
    bus.IReq = 1'b1; bus.IAddr = 16'h0000; bus.DReadEn = 1'b1; bus.DAddr = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      #3;
      exp_d = (i % 5) != 4;
      checkb($sformatf("s2_dgnt_%0d", i), bus.DGnt, exp_d);
      checkb($sformatf("s2_ignt_%0d", i), bus.IGnt, ~exp_d);
      checkb($sformatf("s2_stall_%0d", i), bus.Stall, 1'b1);
      if (exp_d) dq.push_back(32'hD0D02020);
      else       iq.push_back(32'hA0A00000);
    end
    tick(); idle(); #3;

    // Store then load of the same address
    tick();
    bus.DWriteEn = 1'b1; bus.DAddr = 16'h0010; bus.DWData = 32'hDEADBEEF; #3;
    checkb("s3_dgnt", bus.DGnt, 1'b1);
    checkb("s3_memwrite", bus.MemWrite, 1'b1);
    checkb("s3_memread_st", bus.MemRead, 1'b0);
    check("s3_memwdata", bus.MemWData, 32'hDEADBEEF);
    check("s3_memaddr", 32'(bus.MemAddr), 32'h10);
    tick();
    bus.DWriteEn = 1'b0; bus.DWData = 32'h0; bus.DReadEn = 1'b1; #3;
    checkb("s3_no_dvalid_store", bus.DValid, 1'b0);
    checkb("s3_memread_ld", bus.MemRead, 1'b1);
    checkb("s3_memwrite_ld", bus.MemWrite, 1'b0);
    dq.push_back(32'hDEADBEEF);
    tick(); idle(); #3;
    checkb("s3_dvalid", bus.DValid, 1'b1);
    check("s3_drdata", bus.DRData, 32'hDEADBEEF);

    // Alternating single-cycle fetch and load
    for (int i = 0; i < 6; i++) begin
      tick(); idle();
      if (i % 2 == 0) begin bus.IReq = 1'b1; bus.IAddr = 16'h0000; end
      else            begin bus.DReadEn = 1'b1; bus.DAddr = 16'h0020; end
      #3;
      checkb($sformatf("s4_ignt_%0d", i), bus.IGnt, i % 2 == 0);
      checkb($sformatf("s4_dgnt_%0d", i), bus.DGnt, i % 2 == 1);
      checkb($sformatf("s4_stall_%0d", i), bus.Stall, 1'b0);
      if (i > 0) begin
        checkb($sformatf("s4_ivalid_%0d", i), bus.IValid, i % 2 == 1);
        checkb($sformatf("s4_dvalid_%0d", i), bus.DValid, i % 2 == 0);
      end
      if (i % 2 == 0) iq.push_back(32'hA0A00000);
      else            dq.push_back(32'hD0D02020);
    end
    tick(); idle(); #3;

    // Reset right after a fetch grant discards the response
    tick();
    bus.IReq = 1'b1; bus.IAddr = 16'h0004; #3;
    checkb("s5_ignt", bus.IGnt, 1'b1);
    #2;
    nReset = 1'b0; idle(); #1;
    checkb("s5_rst_ivalid", bus.IValid, 1'b0);
    check("s5_rst_idata", bus.IData, 32'h0);
    check("s5_rst_drdata", bus.DRData, 32'h0);
    checkb("s5_rst_memread", bus.MemRead, 1'b0);
    tick(); #2;
    checkb("s5_rst_ivalid2", bus.IValid, 1'b0);
    nReset = 1'b1; #1;
    tick(); #3;
    checkb("s5_post_ivalid", bus.IValid, 1'b0);
    check("s5_post_idata", bus.IData, 32'h0);
    tick();
    bus.IReq = 1'b1; bus.IAddr = 16'h0004; #3;
    checkb("s5_refetch_ignt", bus.IGnt, 1'b1);
    checkb("s5_refetch_stall", bus.Stall, 1'b0);
    iq.push_back(32'h3C011234);
    tick(); idle(); #3;
    checkb("s5_refetch_ivalid", bus.IValid, 1'b1);
    check("s5_refetch_idata", bus.IData, 32'h3C011234);

    // Read and write together behave as a store
    tick();
    bus.DReadEn = 1'b1; bus.DWriteEn = 1'b1; bus.DAddr = 16'h0030; bus.DWData = 32'h12345678; #3;
    checkb("s6_dgnt", bus.DGnt, 1'b1);
    checkb("s6_memwrite", bus.MemWrite, 1'b1);
    checkb("s6_memread", bus.MemRead, 1'b0);
    tick(); idle(); #3;
    checkb("s6_no_dvalid", bus.DValid, 1'b0);
    tick();
    bus.DReadEn = 1'b1; bus.DAddr = 16'h0030; #3;
    dq.push_back(32'h12345678);
    tick(); idle(); #3;
    checkb("s6_dvalid", bus.DValid, 1'b1);
    check("s6_drdata", bus.DRData, 32'h12345678);

    repeat (2) tick();
    #3;
    check("iq_drained", 32'(iq.size()), 32'h0);
    check("dq_drained", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
